// File: rtl/vect_issue_queue_pkg.sv
// Shared types and RVV encodings for the vector instruction issue queue.
// Holds the queue entry layout and the reduction-opcode helper used by the classifier.
package vect_issue_queue_pkg;

  localparam int unsigned VIQ_DW = 32;

  localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
  localparam logic [6:0] OPC_VSTORE = 7'b0100111;

  typedef enum logic [2:0] {
    OPIVV = 3'b000,
    OPFVV = 3'b001,
    OPMVV = 3'b010,
    OPIVI = 3'b011,
    OPIVX = 3'b100,
    OPFVF = 3'b101,
    OPMVX = 3'b110,
    OPCFG = 3'b111
  } vfunct3_e;

  localparam logic [5:0] F6_VSLIDEUP   = 6'b001110;
  localparam logic [5:0] F6_VSLIDEDOWN = 6'b001111;
  localparam logic [5:0] F6_VADC       = 6'b010000;

  // mop field (bits 27:26) value selecting a strided memory access
  localparam logic [1:0] OFF_STRIDE = 2'b10;

  typedef struct packed {
    logic [VIQ_DW-1:0] instr;
    logic [VIQ_DW-1:0] op1;
    logic [VIQ_DW-1:0] op2;
    logic              ext;
  } iq_entry_t;

  // Single-width integer reductions under OPMVV: vredsum .. vredmax
  function automatic logic is_red_funct6(input logic [5:0] f6);
    case (f6)
      6'b000000, 6'b000001, 6'b000010, 6'b000011,
      6'b000100, 6'b000101, 6'b000110, 6'b000111: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vect_instr_classify.sv
// Combinational decode of one vector instruction into a queue entry:
// resolves scalar operands and flags instructions that need the LSU/SLDU.
module vect_instr_classify
  import vect_issue_queue_pkg::*;
(
  input  logic [VIQ_DW-1:0] vinstr_i,
  input  logic [VIQ_DW-1:0] rs1_i,
  input  logic [VIQ_DW-1:0] rs2_i,
  output iq_entry_t         entry_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [5:0] funct6;
  logic       is_mem;

  always_comb begin
    opcode = vinstr_i[6:0];
    funct3 = vinstr_i[14:12];
    funct6 = vinstr_i[31:26];
    is_mem = (opcode == OPC_VLOAD) || (opcode == OPC_VSTORE);

    // unused operand fields stay zero so entries compare deterministically
    entry_o       = '0;
    entry_o.instr = vinstr_i;

    if (is_mem || (funct3 inside {OPIVX, OPFVF, OPMVX})) begin
      entry_o.op1 = rs1_i;
    end else if (funct3 == OPIVI) begin
      entry_o.op1 = {{(VIQ_DW-5){vinstr_i[19]}}, vinstr_i[19:15]};
    end

    if (is_mem && (vinstr_i[27:26] == OFF_STRIDE)) begin
      entry_o.op2 = rs2_i;
    end

    entry_o.ext = is_mem
               || (funct6 == F6_VSLIDEUP) || (funct6 == F6_VSLIDEDOWN)
               || ((funct6 == F6_VADC) && ((funct3 == OPMVV) || (funct3 == OPMVX)))
               || (is_red_funct6(funct6) && (funct3 == OPMVV));
  end

endmodule

// File: rtl/vect_issue_queue.sv
// In-order DEPTH-entry issue queue between the scalar vector-request port and lane dispatch.
// Optional VECT_IQ_BYPASS_EN: an empty queue forwards an incoming instruction combinationally.
module vect_issue_queue
  import vect_issue_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = VIQ_DW,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vreq_i,
  input  logic [DATA_WIDTH-1:0] vinstr_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  output logic                  vready_o,
  output logic                  issue_valid_o,
  output logic [DATA_WIDTH-1:0] issue_instr_o,
  output logic [DATA_WIDTH-1:0] issue_op1_o,
  output logic [DATA_WIDTH-1:0] issue_op2_o,
  output logic                  issue_ext_o,
  input  logic                  issue_ready_i,
  input  logic                  ext_done_i,
  input  logic                  flush_i,
  output logic [CNT_W-1:0]      count_o,
  output logic                  ext_inflight_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  if (DATA_WIDTH != VIQ_DW) begin : g_width_chk
    $error("vect_issue_queue: DATA_WIDTH must equal the package entry width");
  end

  iq_entry_t        mem_q [DEPTH];
  iq_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] shown_idx_q, shown_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ext_inflight_q, ext_inflight_d;

  iq_entry_t        in_entry;
  iq_entry_t        head;
  iq_entry_t        out_entry;
  logic [PTR_W-1:0] head_idx;
  logic             empty, full;
  logic             issue_valid;
  logic             byp_ok, byp_take;
  logic             deq, push, pop;

  vect_instr_classify u_classify (
    .vinstr_i (vinstr_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .entry_o  (in_entry)
  );

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CNT_W'(DEPTH));
    // While empty, keep presenting the slot last shown instead of a stale future slot
    head_idx = empty ? shown_idx_q : rd_ptr_q;
    head     = mem_q[head_idx];

    out_entry   = head;
    issue_valid = !empty && !(head.ext && ext_inflight_q && !ext_done_i);
`ifdef VECT_IQ_BYPASS_EN
    byp_ok = empty && !flush_i && vreq_i && !(in_entry.ext && ext_inflight_q && !ext_done_i);
`else
    byp_ok = 1'b0;
`endif
    if (byp_ok) begin
      out_entry   = in_entry;
      issue_valid = 1'b1;
    end

    byp_take = byp_ok && issue_ready_i;
    deq      = issue_valid && issue_ready_i;
    push     = vreq_i && !full && !flush_i && !byp_take;
    pop      = deq && !byp_take;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end

    shown_idx_d = head_idx;

    // The external unit keeps running through a flush, so only reset clears this
    if (deq && out_entry.ext) begin
      ext_inflight_d = 1'b1;
    end else if (ext_done_i) begin
      ext_inflight_d = 1'b0;
    end else begin
      ext_inflight_d = ext_inflight_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      shown_idx_q    <= '0;
      count_q        <= '0;
      ext_inflight_q <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      shown_idx_q    <= shown_idx_d;
      count_q        <= count_d;
      ext_inflight_q <= ext_inflight_d;
    end
  end

  assign vready_o       = !full;
  assign issue_valid_o  = issue_valid;
  assign issue_instr_o  = out_entry.instr;
  assign issue_op1_o    = out_entry.op1;
  assign issue_op2_o    = out_entry.op2;
  assign issue_ext_o    = out_entry.ext;
  assign count_o        = count_q;
  assign ext_inflight_o = ext_inflight_q;

endmodule

// File: tb/tb_vect_issue_queue.sv
// Directed bench for vect_issue_queue (DEPTH=4): FIFO order, ext blocking, operand
// resolution, flush and reset; expectations adapt when VECT_IQ_BYPASS_EN is defined.
module tb_vect_issue_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        vreq_i;
  logic [31:0] vinstr_i, rs1_i, rs2_i;
  logic        vready_o, issue_valid_o, issue_ext_o;
  logic [31:0] issue_instr_o, issue_op1_o, issue_op2_o;
  logic        issue_ready_i, ext_done_i, flush_i;
  logic [2:0]  count_o;
  logic        ext_inflight_o;

  int n_tests = 0;
  int n_fail  = 0;

  vect_issue_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .vreq_i         (vreq_i),
    .vinstr_i       (vinstr_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .vready_o       (vready_o),
    .issue_valid_o  (issue_valid_o),
    .issue_instr_o  (issue_instr_o),
    .issue_op1_o    (issue_op1_o),
    .issue_op2_o    (issue_op2_o),
    .issue_ext_o    (issue_ext_o),
    .issue_ready_i  (issue_ready_i),
    .ext_done_i     (ext_done_i),
    .flush_i        (flush_i),
    .count_o        (count_o),
    .ext_inflight_o (ext_inflight_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // OP-V arithmetic: funct6, vm=1, vs2=2, rs1/imm field, funct3, vd=1
  function automatic logic [31:0] mk_opv(input logic [5:0] f6, input logic [2:0] f3,
                                         input logic [4:0] f19_15);
    return {f6, 1'b1, 5'd2, f19_15, f3, 5'd1, 7'b1010111};
  endfunction

  function automatic logic [31:0] mk_mem(input logic [6:0] opc, input logic [1:0] mop);
    return {3'b000, 1'b0, mop, 1'b1, 5'd3, 5'd10, 3'b110, 5'd4, opc};
  endfunction

  logic [31:0] vadd_vx, vle, vse, vlse, vadd_vi, vredsum, vslideup;

  initial begin
    vadd_vx  = mk_opv(6'b000000, 3'b100, 5'd5);
    vadd_vi  = mk_opv(6'b000000, 3'b011, 5'b10110);
    vredsum  = mk_opv(6'b000000, 3'b010, 5'd0);
    vslideup = mk_opv(6'b001110, 3'b100, 5'd5);
    vle      = mk_mem(7'b0000111, 2'b00);
    vse      = mk_mem(7'b0100111, 2'b00);
    vlse     = mk_mem(7'b0000111, 2'b10);

    rst_i = 1'b1; vreq_i = 1'b0; vinstr_i = '0; rs1_i = '0; rs2_i = '0;
    issue_ready_i = 1'b0; ext_done_i = 1'b0; flush_i = 1'b0;
    repeat (2) cyc();
    rst_i = 1'b0;
    #1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_inflight", 32'(ext_inflight_o), 0);
    chk("rst_valid", 32'(issue_valid_o), 0);
    chk("rst_instr", issue_instr_o, 0);
    chk("rst_op1", issue_op1_o, 0);
    chk("rst_op2", issue_op2_o, 0);
    chk("rst_vready", 32'(vready_o), 1);

    // single VADD.VX
    vinstr_i = vadd_vx; rs1_i = 32'h1234; rs2_i = 32'h5555; vreq_i = 1'b1;
    #1;
`ifdef VECT_IQ_BYPASS_EN
    chk("vx_same_cycle_valid", 32'(issue_valid_o), 1);
`else
    chk("vx_same_cycle_valid", 32'(issue_valid_o), 0);
`endif
    cyc();
    vreq_i = 1'b0;
    #1;
    chk("vx_valid", 32'(issue_valid_o), 1);
    chk("vx_instr", issue_instr_o, vadd_vx);
    chk("vx_op1", issue_op1_o, 32'h1234);
    chk("vx_op2", issue_op2_o, 0);
    chk("vx_ext", 32'(issue_ext_o), 0);
    chk("vx_count", 32'(count_o), 1);
    issue_ready_i = 1'b1;
    cyc();
    issue_ready_i = 1'b0;
    #1;
    chk("vx_drained_count", 32'(count_o), 0);
    chk("vx_drained_valid", 32'(issue_valid_o), 0);

    // fill to full starting at pointer 1, so the drain wraps
    for (int i = 0; i < 4; i++) begin
      vinstr_i = mk_opv(6'b000000, 3'b000, 5'(i)); vreq_i = 1'b1;
      cyc();
    end
    vreq_i = 1'b0;
    #1;
    chk("full_vready", 32'(vready_o), 0);
    chk("full_count", 32'(count_o), 4);
    vinstr_i = mk_opv(6'b000000, 3'b000, 5'd9); vreq_i = 1'b1;
    cyc();
    vreq_i = 1'b0;
    #1;
    chk("drop5_count", 32'(count_o), 4);
    chk("drop5_head", issue_instr_o, mk_opv(6'b000000, 3'b000, 5'd0));
    issue_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", 32'(issue_valid_o), 1);
      chk("drain_order", issue_instr_o, mk_opv(6'b000000, 3'b000, 5'(i)));
      cyc();
    end
    issue_ready_i = 1'b0;
    #1;
    chk("drain_empty_count", 32'(count_o), 0);
    chk("drain_empty_valid", 32'(issue_valid_o), 0);

    // VLE then VSE: second ext blocked until ext_done
    vinstr_i = vle; rs1_i = 32'h80; vreq_i = 1'b1;
    cyc();
    vinstr_i = vse; issue_ready_i = 1'b1;
    #1;
    chk("vle_valid", 32'(issue_valid_o), 1);
    chk("vle_instr", issue_instr_o, vle);
    chk("vle_ext", 32'(issue_ext_o), 1);
    chk("vle_op1", issue_op1_o, 32'h80);
    chk("vle_op2", issue_op2_o, 0);
    cyc();
    vreq_i = 1'b0;
    #1;
    chk("vse_inflight", 32'(ext_inflight_o), 1);
    chk("vse_count", 32'(count_o), 1);
    chk("vse_blocked", 32'(issue_valid_o), 0);
    chk("vse_instr", issue_instr_o, vse);
    cyc();
    chk("vse_still_blocked", 32'(issue_valid_o), 0);
    ext_done_i = 1'b1;
    #1;
    chk("vse_done_unblock", 32'(issue_valid_o), 1);
    cyc();
    ext_done_i = 1'b0;
    #1;
    chk("vse_inflight_kept", 32'(ext_inflight_o), 1);
    chk("vse_issued_count", 32'(count_o), 0);
    ext_done_i = 1'b1;
    cyc();
    ext_done_i = 1'b0;
    #1;
    chk("vse_done_clear", 32'(ext_inflight_o), 0);

    // operand resolution and classification
    issue_ready_i = 1'b0; rs1_i = 32'h77; vreq_i = 1'b1;
    vinstr_i = vadd_vi;                              cyc();
    vinstr_i = mk_opv(6'b000000, 3'b000, 5'd3);      cyc();
    vinstr_i = vredsum;                              cyc();
    vinstr_i = vslideup;                             cyc();
    vreq_i = 1'b0; issue_ready_i = 1'b1;
    #1;
    chk("vi_op1_sext", issue_op1_o, 32'hFFFF_FFF6);
    chk("vi_ext", 32'(issue_ext_o), 0);
    cyc();
    chk("vv_op1_zero", issue_op1_o, 0);
    chk("vv_ext", 32'(issue_ext_o), 0);
    cyc();
    chk("red_ext", 32'(issue_ext_o), 1);
    chk("red_op1_zero", issue_op1_o, 0);
    cyc();
    chk("slide_ext", 32'(issue_ext_o), 1);
    chk("slide_op1", issue_op1_o, 32'h77);
    chk("slide_blocked", 32'(issue_valid_o), 0);
    ext_done_i = 1'b1;
    cyc();
    ext_done_i = 1'b0;
    #1;
    chk("slide_inflight", 32'(ext_inflight_o), 1);
    chk("slide_count", 32'(count_o), 0);

    // strided load, then flush with ext outstanding
    issue_ready_i = 1'b0; vinstr_i = vlse; rs1_i = 32'h80; rs2_i = 32'h40; vreq_i = 1'b1;
    cyc();
    vreq_i = 1'b0;
    #1;
    chk("vlse_op2", issue_op2_o, 32'h40);
    chk("vlse_op1", issue_op1_o, 32'h80);
    chk("vlse_blocked", 32'(issue_valid_o), 0);
    vinstr_i = vadd_vx; vreq_i = 1'b1;
    cyc();
    cyc();
    vreq_i = 1'b0;
    #1;
    chk("pre_flush_count", 32'(count_o), 3);
    flush_i = 1'b1; vreq_i = 1'b1;
    cyc();
    flush_i = 1'b0; vreq_i = 1'b0;
    #1;
    chk("flush_count", 32'(count_o), 0);
    chk("flush_inflight", 32'(ext_inflight_o), 1);
    chk("flush_valid", 32'(issue_valid_o), 0);
    chk("flush_vready", 32'(vready_o), 1);
    cyc();
    chk("flush_drop_count", 32'(count_o), 0);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    #1;
    chk("rst2_inflight", 32'(ext_inflight_o), 0);
    chk("rst2_count", 32'(count_o), 0);
    ext_done_i = 1'b1;
    cyc();
    ext_done_i = 1'b0;
    #1;
    chk("rst2_done_ignored", 32'(ext_inflight_o), 0);

    // empty-queue accept with lanes ready
    vinstr_i = vadd_vx; rs1_i = 32'h1234; vreq_i = 1'b1; issue_ready_i = 1'b1;
    #1;
`ifdef VECT_IQ_BYPASS_EN
    chk("byp_valid", 32'(issue_valid_o), 1);
    chk("byp_op1", issue_op1_o, 32'h1234);
    cyc();
    vreq_i = 1'b0;
    #1;
    chk("byp_count", 32'(count_o), 0);
    chk("byp_after_valid", 32'(issue_valid_o), 0);
`else
    chk("nobyp_same_valid", 32'(issue_valid_o), 0);
    cyc();
    vreq_i = 1'b0;
    #1;
    chk("nobyp_next_valid", 32'(issue_valid_o), 1);
    chk("nobyp_count", 32'(count_o), 1);
    chk("nobyp_op1", issue_op1_o, 32'h1234);
    cyc();
    chk("nobyp_drained", 32'(count_o), 0);
`endif
    issue_ready_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
